wb_regfile: RTL and testbench

- Consumer end of the MEM/WB pipeline register: the writeback stage merged with the architectural register file.
- Takes the MEM/WB outputs and selects the writeback value (ALU result or load data). Writes the register file.
- Serves two combinational read ports to the ID stage.
- Keeps a registered commit record and a retired-write counter for debug and trace.

---
 rtl/wb_regfile.sv | 102 ++++++++++
 tb/tb_wb_regfile.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage merged with the architectural register file: wb value select, 2 read ports,
// registered commit record and retired-write counter. Optional forwarding: WB_BYPASS_EN.
`ifndef DSIZE
`define DSIZE 32
`endif
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef ISIZE
`define ISIZE 32
`endif

module wb_regfile #(
  parameter int unsigned DSIZE = `DSIZE,
  parameter int unsigned ASIZE = `ASIZE,
  parameter int unsigned ISIZE = `ISIZE,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [ASIZE-1:0] w_addr,
  input  logic [DSIZE-1:0] w_data,
  input  logic             MemtoReg,
  input  logic [DSIZE-1:0] readMem,
  input  logic [ISIZE-1:0] PC,
  input  logic [ASIZE-1:0] raddr1,
  input  logic [ASIZE-1:0] raddr2,
  output logic [DSIZE-1:0] rdata1,
  output logic [DSIZE-1:0] rdata2,
  output logic             commit_valid,
  output logic [ISIZE-1:0] commit_pc,
  output logic [ASIZE-1:0] commit_addr,
  output logic [DSIZE-1:0] commit_data,
  output logic [CNT_W-1:0] commit_count
);

  localparam int unsigned NumRegs = 2 ** ASIZE;

  logic [DSIZE-1:0] r_regs [NumRegs];
  logic             r_valid;
  logic [ISIZE-1:0] r_pc;
  logic [ASIZE-1:0] r_addr;
  logic [DSIZE-1:0] r_data;
  logic [CNT_W-1:0] r_count;

  logic [DSIZE-1:0] w_wb_val;
  logic             w_reg_we;

  assign w_wb_val = MemtoReg ? readMem : w_data;
  assign w_reg_we = wen && (w_addr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_reg_we) begin
      r_regs[w_addr] <= w_wb_val;
    end
  end

  // Commit record captures every retired write, including the r0 ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_valid <= wen;
      if (wen) begin
        r_pc    <= PC;
        r_addr  <= w_addr;
        r_data  <= w_wb_val;
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : r_regs[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : r_regs[raddr2];
`ifdef WB_BYPASS_EN
    // Forward only when the write will actually land on the coming edge.
    if (rst && w_reg_we && (raddr1 == w_addr)) begin
      rdata1 = w_wb_val;
    end
    if (rst && w_reg_we && (raddr2 == w_addr)) begin
      rdata2 = w_wb_val;
    end
`endif
  end

  assign commit_valid = r_valid;
  assign commit_pc    = r_pc;
  assign commit_addr  = r_addr;
  assign commit_data  = r_data;
  assign commit_count = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic against an
// array-based reference model of the register file and commit record.
module tb_wb_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned IW = 16;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wen = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic          MemtoReg = 1'b0;
  logic [DW-1:0] readMem = '0;
  logic [IW-1:0] PC = '0;
  logic [AW-1:0] raddr1 = '0;
  logic [AW-1:0] raddr2 = '0;
  logic [DW-1:0] rdata1, rdata2;
  logic          commit_valid;
  logic [IW-1:0] commit_pc;
  logic [AW-1:0] commit_addr;
  logic [DW-1:0] commit_data;
  logic [CW-1:0] commit_count;

  wb_regfile #(.DSIZE(DW), .ASIZE(AW), .ISIZE(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .wen(wen), .w_addr(w_addr), .w_data(w_data),
    .MemtoReg(MemtoReg), .readMem(readMem), .PC(PC), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_addr(commit_addr), .commit_data(commit_data), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [DW-1:0] m_regs [32];
  logic          m_valid;
  logic [IW-1:0] m_pc;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_count;

  function automatic logic [DW-1:0] wb_value();
    return MemtoReg ? readMem : w_data;
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef WB_BYPASS_EN
    if (rst && wen && w_addr != 0 && w_addr == a) return wb_value();
`endif
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_valid = 1'b0; m_pc = '0; m_addr = '0; m_data = '0; m_count = 0;
  endtask

  // Advance one clock, applying the model update for whatever the inputs are at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (wen) begin
      if (w_addr != 0) m_regs[w_addr] = wb_value();
      m_valid = 1'b1; m_pc = PC; m_addr = w_addr; m_data = wb_value(); m_count++;
    end else begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic m2r, input logic [DW-1:0] rm, input logic [IW-1:0] pc,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    wen = we; w_addr = wa; w_data = wd; MemtoReg = m2r; readMem = rm; PC = pc;
    raddr1 = r1; raddr2 = r2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd5, 5'd31);
    tick(); tick();
    rst = 1'b1;
    #1;
    n_tests++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata1 got %h exp 0", rdata1); end
    n_tests++; if (rdata2 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata2 got %h exp 0", rdata2); end
    n_tests++; if (commit_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", commit_count); end
    n_tests++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", commit_valid); end
    n_tests++; if (commit_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", commit_data); end
  endtask

  task automatic test_alu_wb();
    drive(1'b1, 5'd3, 32'h1234, 1'b0, 32'h9999, 16'h40, 5'd3, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 16'h44, 5'd3, 5'd0);
    #1;
    n_tests++; if (rdata1 !== 32'h1234) begin n_fail++; $display("FAIL alu_rdata got %h exp 1234", rdata1); end
    n_tests++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid got %b exp 1", commit_valid); end
    n_tests++; if (commit_pc !== 16'h40) begin n_fail++; $display("FAIL alu_pc got %h exp 40", commit_pc); end
    n_tests++; if (commit_addr !== 5'd3) begin n_fail++; $display("FAIL alu_addr got %0d exp 3", commit_addr); end
    n_tests++; if (commit_data !== 32'h1234) begin n_fail++; $display("FAIL alu_data got %h exp 1234", commit_data); end
    n_tests++; if (commit_count !== 4'd1) begin n_fail++; $display("FAIL alu_count got %0d exp 1", commit_count); end
    tick();
    n_tests++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL alu_idle_valid got %b exp 0", commit_valid); end
    n_tests++; if (commit_data !== 32'h1234) begin n_fail++; $display("FAIL alu_hold_data got %h exp 1234", commit_data); end
  endtask

  task automatic test_load_wb();
    drive(1'b1, 5'd7, 32'hAAAA, 1'b1, 32'hBEEF, 16'h48, 5'd7, 5'd7);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 16'h4C, 5'd7, 5'd3);
    #1;
    n_tests++; if (rdata1 !== 32'hBEEF) begin n_fail++; $display("FAIL load_rdata got %h exp beef", rdata1); end
    n_tests++; if (rdata2 !== 32'h1234) begin n_fail++; $display("FAIL load_r3 got %h exp 1234", rdata2); end
    n_tests++; if (commit_data !== 32'hBEEF) begin n_fail++; $display("FAIL load_data got %h exp beef", commit_data); end
    n_tests++; if (commit_count !== 4'd2) begin n_fail++; $display("FAIL load_count got %0d exp 2", commit_count); end
    tick();
  endtask

  task automatic test_r0_discard();
    drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 32'h0, 16'h50, 5'd0, 5'd0);
    #1;
    n_tests++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL r0_same_cycle got %h exp 0", rdata1); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 16'h54, 5'd0, 5'd7);
    #1;
    n_tests++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL r0_read got %h exp 0", rdata1); end
    n_tests++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL r0_valid got %b exp 1", commit_valid); end
    n_tests++; if (commit_addr !== 5'd0) begin n_fail++; $display("FAIL r0_addr got %0d exp 0", commit_addr); end
    n_tests++; if (commit_data !== 32'hFFFF) begin n_fail++; $display("FAIL r0_data got %h exp ffff", commit_data); end
    n_tests++; if (commit_count !== 4'd3) begin n_fail++; $display("FAIL r0_count got %0d exp 3", commit_count); end
    tick();
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] exp;
`ifdef WB_BYPASS_EN
    exp = 32'h55;
`else
    exp = 32'h11;
`endif
    drive(1'b1, 5'd9, 32'h11, 1'b0, 32'h0, 16'h60, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd9, 32'h55, 1'b0, 32'h0, 16'h64, 5'd9, 5'd9);
    #1;
    n_tests++; if (rdata1 !== exp) begin n_fail++; $display("FAIL same_rdata1 got %h exp %h", rdata1, exp); end
    n_tests++; if (rdata2 !== exp) begin n_fail++; $display("FAIL same_rdata2 got %h exp %h", rdata2, exp); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 16'h68, 5'd9, 5'd9);
    #1;
    n_tests++; if (rdata1 !== 32'h55) begin n_fail++; $display("FAIL same_after got %h exp 55", rdata1); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] wa, r1, r2;
      wa = AW'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
      drive($urandom_range(0, 3) != 0, wa, $urandom, 1'($urandom_range(0, 1)), $urandom,
            IW'($urandom), r1, r2);
      #1;
      n_tests++;
      if (rdata1 !== exp_read(r1)) begin
        n_fail++; $display("FAIL rand_rdata1 addr %0d got %h exp %h", r1, rdata1, exp_read(r1));
      end
      n_tests++;
      if (rdata2 !== exp_read(r2)) begin
        n_fail++; $display("FAIL rand_rdata2 addr %0d got %h exp %h", r2, rdata2, exp_read(r2));
      end
      tick();
      n_tests++;
      if ({commit_valid, commit_pc, commit_addr, commit_data} !== {m_valid, m_pc, m_addr, m_data}) begin
        n_fail++;
        $display("FAIL rand_commit got %b/%h/%0d/%h exp %b/%h/%0d/%h", commit_valid, commit_pc,
                 commit_addr, commit_data, m_valid, m_pc, m_addr, m_data);
      end
      n_tests++;
      if (commit_count !== CW'(m_count % 16)) begin
        n_fail++; $display("FAIL rand_count got %0d exp %0d", commit_count, m_count % 16);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd4, 32'h77, 1'b0, 32'h0, 16'h70, 5'd4, 5'd0);
    tick();
    drive(1'b1, 5'd4, 32'h99, 1'b0, 32'h0, 16'h74, 5'd4, 5'd4);
    #1;
    n_tests++; if (rdata2 !== exp_read(5'd4)) begin n_fail++; $display("FAIL ar_pre got %h exp %h", rdata2, exp_read(5'd4)); end
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    n_tests++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL ar_r4 got %h exp 0", rdata1); end
    n_tests++;
    if ({commit_valid, commit_pc, commit_addr, commit_data, commit_count} !== '0) begin
      n_fail++;
      $display("FAIL ar_commit got %b/%h/%0d/%h/%0d exp all 0", commit_valid, commit_pc,
               commit_addr, commit_data, commit_count);
    end
    tick();
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 16'h78, 5'd4, 5'd4);
    tick();
    n_tests++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL ar_release got %h exp 0", rdata1); end
    n_tests++; if (commit_count !== 4'd0) begin n_fail++; $display("FAIL ar_count got %0d exp 0", commit_count); end
    drive(1'b1, 5'd4, 32'h0, 1'b1, 32'hC0DE, 16'h7C, 5'd4, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 16'h80, 5'd4, 5'd0);
    #1;
    n_tests++; if (rdata1 !== 32'hC0DE) begin n_fail++; $display("FAIL ar_rewrite got %h exp c0de", rdata1); end
    n_tests++; if (commit_count !== 4'd1) begin n_fail++; $display("FAIL ar_recount got %0d exp 1", commit_count); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_alu_wb();
    test_load_wb();
    test_r0_discard();
    test_same_cycle();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
